// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the signals of alu_op_sequencer other than clock and reset.
//   req0_* / req1_* : two issue ports (valid, ready, a, b, op)
//   alu_*           : registered operands/opcode to the ALU, result and flags back
//   rsp_*           : response channel (valid, ready, id, result, flags)
//   busy            : sequencer has an op in flight
// Modports:
//   slave  - the sequencer itself
//   master - its environment (requesters, ALU, response consumer)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic [31:0] alu_flags;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [31:0] rsp_flags;

    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Two-requester front end for a combinational ALU. Arbitrates round-robin
// between two issue ports, registers the granted operands onto the ALU, holds
// them for a per-op cycle budget (MUL/DIV are multicycle paths), then captures
// the ALU result and flags into a response register.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   bus       slave modport of alu_op_sequencer_if (issue ports, ALU, response)
//   dbg_state out  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Parameters:
//   MUL_CYCLES  cycles the ALU inputs are held for op 3'b100 (>=1)
//   DIV_CYCLES  cycles the ALU inputs are held for op 3'b101 (>=1)
//
// Optional feature macro: ALU_SEQ_DIV0_FAST_EN
//   When defined, a divide by zero is captured after one cycle, since the ALU
//   produces its zero/invalid result without the long divide path.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready is combinational and only high in IDLE for the
// granted requester; a requester may drop valid at any time before that.
// rsp_valid stays high with stable rsp_* until rsp_ready is seen high.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_L) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_grant;

    logic               grant_any;
    logic               grant_id;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_op;
    logic [CNT_W-1:0]   sel_lm1;

    // Grant: sole valid requester, or on a tie the one not served last.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_id  = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        sel_a     = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b     = grant_id ? bus.req1_b  : bus.req0_b;
        sel_op    = grant_id ? bus.req1_op : bus.req0_op;
    end

    // Hold budget minus one; the counter reaches zero in the final EXEC cycle.
    always_comb begin
        sel_lm1 = '0;
        if (sel_op == 3'b100) begin
            sel_lm1 = CNT_W'(MUL_CYCLES - 1);
        end else if (sel_op == 3'b101) begin
`ifdef ALU_SEQ_DIV0_FAST_EN
            if (sel_b == 32'd0)
                sel_lm1 = '0;
            else
                sel_lm1 = CNT_W'(DIV_CYCLES - 1);
`else
            sel_lm1 = CNT_W'(DIV_CYCLES - 1);
`endif
        end
    end

    assign bus.req0_ready = (state == IDLE) && grant_any && !grant_id;
    assign bus.req1_ready = (state == IDLE) && grant_any &&  grant_id;
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last_grant     <= 1'b1;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_op     <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_flags  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        bus.alu_a  <= sel_a;
                        bus.alu_b  <= sel_b;
                        bus.alu_op <= sel_op;
                        bus.rsp_id <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= sel_lm1;
                        bus.busy   <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.rsp_result <= bus.alu_out;
                        bus.rsp_flags  <= bus.alu_flags;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
